mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter LAT, default 2, data memory access latency in cycles; legal range 1..7.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  memory-stage access request; held until cpu_stall falls.
REQ-005 cpu_we  input  2  store-size code; 0 means load.
REQ-006 cpu_ldtype  input  3  load extension/size code.
REQ-007 cpu_addr, cpu_wdata  input  32 each  memory-stage address and store data.
REQ-008 cpu_stall  output  1  freeze the pipeline at and before the memory stage.
REQ-009 cpu_rdata  output  32  load result; valid while cpu_stall is low after a CPU access.
REQ-010 dma_req  input  1  secondary-port request; held with stable fields until dma_ack.
REQ-011 dma_we, dma_addr, dma_wdata  input  2/32/32  secondary-port access fields; loads are word-wide (ldtype 0).
REQ-012 dma_ack  output  1  one-cycle completion pulse.
REQ-013 dma_rdata  output  32  DMA load result; valid during dma_ack.
REQ-014 mem_we, mem_ldtype, mem_addr, mem_wdata  output  2/3/32/32  drive to the data memory.
REQ-015 mem_rdata  input  32  data memory read data.

Function
REQ-016 FSM states are IDLE, BUSY and DONE; the owner register is CPU or DMA, and the last-grant register is CPU or DMA.
REQ-017 Eligible requests are cpu_req and dma_req, except that in DONE the current owner's request is masked.
REQ-018 IDLE or DONE with one eligible request grants it: owner <= requester, fields latched, cnt <= LAT-1, next state BUSY.
REQ-019 With both eligible, the grant goes to the requester that is not last-grant (round robin), and last-grant <= winner.
REQ-020 DONE with no eligible request -> IDLE; IDLE with no request stays IDLE.
REQ-021 BUSY decrements cnt each cycle; at cnt==0, mem_rdata is captured into the owner's rdata register and the next state is DONE.
REQ-022 mem_addr, mem_wdata and mem_ldtype hold the latched fields throughout BUSY and are 0 otherwise.
REQ-023 mem_we equals the latched we only in the final BUSY cycle (cnt==0), and is 0 otherwise, so each store commits exactly once.
REQ-024 cpu_stall = cpu_req AND NOT (state==DONE AND owner==CPU), combinational.
REQ-025 A CPU access stalls for LAT+1 cycles, then cpu_stall is low for the DONE cycle.
REQ-026 dma_ack = (state==DONE AND owner==DMA); the DMA port drops or renews dma_req in the following cycle.
REQ-027 A DONE cycle may grant the other requester directly, giving back-to-back accesses with no IDLE gap.
REQ-028 cpu_rdata and dma_rdata hold their last captured value until the next capture for that port.

Reset
REQ-029 While RESET is high: state IDLE, cnt 0, owner CPU, last-grant DMA, cpu_rdata and dma_rdata 0, all mem_* outputs 0, dma_ack 0.
REQ-030 RESET during BUSY aborts the access: no mem_we pulse, no ack and no capture, even when asserted in the cnt==0 cycle.

Verification
REQ-031 LAT=2, CPU load addr 0x10 with mem returning 0x1234ABCD -> cpu_stall high for 3 cycles, then low with cpu_rdata=0x1234ABCD.
REQ-032 CPU store we=3, addr 0x20, data 0xDEADBEEF -> mem_we=3 for exactly one cycle, with mem_addr=0x20 and mem_wdata=0xDEADBEEF.
REQ-033 cpu_req and dma_req rising together after reset -> CPU served first, DMA granted in the CPU DONE cycle, dma_ack 3 cycles later.
REQ-034 Both requesters held continuously -> grants strictly alternate CPU, DMA, CPU, DMA with no IDLE cycles.
REQ-035 RESET pulsed in the cnt==0 cycle of a DMA store -> mem_we stays 0, dma_ack never fires, state IDLE next cycle.
REQ-036 LAT=1, lone DMA load -> dma_ack exactly 2 cycles after the grant cycle, carrying mem_rdata.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Arbitrates a CPU memory-stage port and a DMA port onto one fixed-latency data memory.
// Round-robin grant; each access holds the memory for LAT cycles and then completes in a DONE cycle.
module mem_access_ctrl #(
    parameter int LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_we,
    input  logic [2:0]  cpu_ldtype,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [1:0]  dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [1:0]  mem_we,
    output logic [2:0]  mem_ldtype,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DMA  = 1'b1;
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [1:0]  f_we_q, f_we_d;
    logic [2:0]  f_ldtype_q, f_ldtype_d;
    logic [31:0] f_addr_q, f_addr_d;
    logic [31:0] f_wdata_q, f_wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    logic cpu_done, dma_done, cpu_elig, dma_elig, grant_dma, busy;

    assign cpu_done = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign dma_done = (state_q == S_DONE) && (owner_q == OWN_DMA);
    // The owner finishing in DONE is masked so the other side can be granted without an IDLE gap.
    assign cpu_elig  = cpu_req && !cpu_done;
    assign dma_elig  = dma_req && !dma_done;
    assign grant_dma = dma_elig && (!cpu_elig || (last_q == OWN_CPU));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        f_we_d      = f_we_q;
        f_ldtype_d  = f_ldtype_q;
        f_addr_d    = f_addr_q;
        f_wdata_d   = f_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            S_BUSY: begin
                if (cnt_q == 3'd0) begin
                    if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
                    else                    cpu_rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                if (cpu_elig || dma_elig) begin
                    state_d    = S_BUSY;
                    owner_d    = grant_dma;
                    last_d     = grant_dma;
                    cnt_d      = CNT_INIT;
                    f_we_d     = grant_dma ? dma_we    : cpu_we;
                    f_ldtype_d = grant_dma ? 3'd0      : cpu_ldtype;
                    f_addr_d   = grant_dma ? dma_addr  : cpu_addr;
                    f_wdata_d  = grant_dma ? dma_wdata : cpu_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DMA;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Latched access fields are only observed while BUSY, so they need no reset.
    always_ff @(posedge CLK) begin
        f_we_q     <= f_we_d;
        f_ldtype_q <= f_ldtype_d;
        f_addr_q   <= f_addr_d;
        f_wdata_q  <= f_wdata_d;
    end

    // Gating with RESET kills the store strobe even when reset lands in the final BUSY cycle.
    assign busy       = (state_q == S_BUSY) && !RESET;
    assign mem_addr   = busy ? f_addr_q   : '0;
    assign mem_wdata  = busy ? f_wdata_q  : '0;
    assign mem_ldtype = busy ? f_ldtype_q : '0;
    assign mem_we     = (busy && (cnt_q == 3'd0)) ? f_we_q : '0;

    assign cpu_stall = cpu_req && !cpu_done;
    assign dma_ack   = dma_done && !RESET;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a LAT=2 instance for arbitration/store/reset cases
// and a LAT=1 instance for the minimum-latency DMA load.
module tb_mem_access_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RESET;

    logic        cpu_req, cpu_stall, dma_req, dma_ack;
    logic [1:0]  cpu_we, dma_we, mem_we;
    logic [2:0]  cpu_ldtype, mem_ldtype;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        d1_cpu_req, d1_cpu_stall, d1_dma_req, d1_dma_ack;
    logic [1:0]  d1_cpu_we, d1_dma_we, d1_mem_we;
    logic [2:0]  d1_cpu_ldtype, d1_mem_ldtype;
    logic [31:0] d1_cpu_addr, d1_cpu_wdata, d1_cpu_rdata, d1_dma_addr, d1_dma_wdata, d1_dma_rdata;
    logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h1234ABCD;
        return a ^ 32'hA5A5_0F0F;
    endfunction

    assign mem_rdata    = mem_val(mem_addr);
    assign d1_mem_rdata = mem_val(d1_mem_addr);

    mem_access_ctrl #(.LAT(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ldtype(cpu_ldtype),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_ldtype(mem_ldtype), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.LAT(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(d1_cpu_req), .cpu_we(d1_cpu_we), .cpu_ldtype(d1_cpu_ldtype),
        .cpu_addr(d1_cpu_addr), .cpu_wdata(d1_cpu_wdata),
        .cpu_stall(d1_cpu_stall), .cpu_rdata(d1_cpu_rdata),
        .dma_req(d1_dma_req), .dma_we(d1_dma_we), .dma_addr(d1_dma_addr), .dma_wdata(d1_dma_wdata),
        .dma_ack(d1_dma_ack), .dma_rdata(d1_dma_rdata),
        .mem_we(d1_mem_we), .mem_ldtype(d1_mem_ldtype), .mem_addr(d1_mem_addr),
        .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  we;
    } wr_t;

    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_dma_q[$];
    wr_t         exp_wr_q[$];

    // Completion monitor: every store strobe, CPU completion and DMA ack pops its queue.
    always @(negedge CLK) begin
        wr_t e;
        if (!RESET) begin
            if (mem_we != 2'd0) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'(mem_we), 0);
                else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_we", 32'(mem_we), 32'(e.we));
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
            end
            if (cpu_req && !cpu_stall) begin
                if (exp_cpu_q.size() == 0) chk("cpu_unexpected", 1, 0);
                else chk("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
            end
            if (dma_ack) begin
                if (exp_dma_q.size() == 0) chk("dma_unexpected", 1, 0);
                else chk("dma_rdata", dma_rdata, exp_dma_q.pop_front());
            end
        end
    end

    task automatic cpu_access(input logic [1:0] we, input logic [2:0] ld, input logic [31:0] a,
                              input logic [31:0] d, output int stall_n, output int we_n);
        bit done = 0;
        @(posedge CLK); #1;
        cpu_req = 1; cpu_we = we; cpu_ldtype = ld; cpu_addr = a; cpu_wdata = d;
        stall_n = 0; we_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (mem_we != 2'd0) we_n++;
            if (i > 0 && cpu_stall) begin
                chk("cpu_busy_addr", mem_addr, a);
                chk("cpu_busy_ldtype", 32'(mem_ldtype), 32'(ld));
            end
            if (!cpu_stall) begin
                done = 1;
                break;
            end
            stall_n++;
        end
        if (!done) chk("cpu_timeout", 0, 1);
        @(posedge CLK); #1;
        cpu_req = 0; cpu_we = 0; cpu_ldtype = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s, w, cpu_c, dma_c, k, cpu_n, dma_n, ack_c, bad;
        int seq[4];
        int cyc[4];
        RESET = 1;
        cpu_req = 0; cpu_we = 0; cpu_ldtype = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        d1_cpu_req = 0; d1_cpu_we = 0; d1_cpu_ldtype = 0; d1_cpu_addr = 0; d1_cpu_wdata = 0;
        d1_dma_req = 0; d1_dma_we = 0; d1_dma_addr = 0; d1_dma_wdata = 0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_ack", 32'(dma_ack), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        @(posedge CLK); #1;
        RESET = 0;

        exp_cpu_q.push_back(32'h1234ABCD);
        cpu_access(2'd0, 3'd0, 32'h10, 32'h0, s, w);
        chk("ld_stall_cycles", s, 3);
        chk("ld_we_pulses", w, 0);
        chk("ld_rdata_hold", cpu_rdata, 32'h1234ABCD);

        exp_wr_q.push_back('{a: 32'h20, d: 32'hDEADBEEF, we: 2'd3});
        exp_cpu_q.push_back(mem_val(32'h20));
        cpu_access(2'd3, 3'd0, 32'h20, 32'hDEADBEEF, s, w);
        chk("st_stall_cycles", s, 3);
        chk("st_we_pulses", w, 1);

        exp_cpu_q.push_back(mem_val(32'h24));
        cpu_access(2'd0, 3'd5, 32'h24, 32'h0, s, w);
        chk("ldt_stall_cycles", s, 3);

        // Simultaneous requests right after reset
        @(posedge CLK); #1; RESET = 1;
        @(posedge CLK); #1; RESET = 0;
        @(posedge CLK); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        dma_req = 1; dma_we = 0; dma_addr = 32'h40;
        exp_cpu_q.push_back(mem_val(32'h30));
        exp_dma_q.push_back(mem_val(32'h40));
        cpu_c = -1; dma_c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (cpu_req && !cpu_stall && cpu_c < 0) cpu_c = i;
            if (dma_ack) begin
                dma_c = i;
                break;
            end
            @(posedge CLK); #1;
            if (cpu_c >= 0) cpu_req = 0;
        end
        @(posedge CLK); #1;
        cpu_req = 0; dma_req = 0;
        chk("both_cpu_done_cycle", cpu_c, 3);
        chk("both_dma_ack_cycle", dma_c, 6);

        // Both held: strict alternation with no idle gaps
        @(posedge CLK); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
        dma_req = 1; dma_we = 2'd2; dma_addr = 32'h60; dma_wdata = 32'hCAFEF00D;
        for (int j = 0; j < 2; j++) begin
            exp_cpu_q.push_back(mem_val(32'h50));
            exp_dma_q.push_back(mem_val(32'h60));
            exp_wr_q.push_back('{a: 32'h60, d: 32'hCAFEF00D, we: 2'd2});
        end
        k = 0; cpu_n = 0; dma_n = 0;
        for (int j = 0; j < 4; j++) begin seq[j] = -1; cyc[j] = -1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (cpu_req && !cpu_stall && k < 4) begin seq[k] = 0; cyc[k] = i; k++; cpu_n++; end
            if (dma_ack && k < 4) begin seq[k] = 1; cyc[k] = i; k++; dma_n++; end
            if (k == 4) break;
            @(posedge CLK); #1;
            if (cpu_n == 2) cpu_req = 0;
            if (dma_n == 2) dma_req = 0;
        end
        @(posedge CLK); #1;
        cpu_req = 0; dma_req = 0; dma_we = 0;
        for (int j = 0; j < 4; j++) begin
            chk("alt_owner", seq[j], j % 2);
            chk("alt_cycle", cyc[j], 3 * (j + 1));
        end

        // Reset landing in the final BUSY cycle of a DMA store
        @(posedge CLK); #1;
        dma_req = 1; dma_we = 2'd1; dma_addr = 32'h70; dma_wdata = 32'h11223344;
        @(negedge CLK);
        chk("rsb_c0_addr", mem_addr, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rsb_c1_addr", mem_addr, 32'h70);
        chk("rsb_c1_we", 32'(mem_we), 0);
        chk("rsb_cpu_hold", cpu_rdata, mem_val(32'h50));
        @(posedge CLK); #1;
        RESET = 1;
        @(negedge CLK);
        chk("rsb_c2_we", 32'(mem_we), 0);
        chk("rsb_c2_ack", 32'(dma_ack), 0);
        chk("rsb_c2_addr", mem_addr, 0);
        @(posedge CLK); #1;
        RESET = 0; dma_req = 0; dma_we = 0;
        @(negedge CLK);
        chk("rsb_c3_ack", 32'(dma_ack), 0);
        chk("rsb_c3_addr", mem_addr, 0);
        chk("rsb_c3_dma_rdata", dma_rdata, 0);
        chk("rsb_c3_cpu_rdata", cpu_rdata, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (dma_ack || mem_we != 2'd0) bad++;
        end
        chk("rsb_quiet_after", bad, 0);

        // LAT=1 lone DMA load
        @(posedge CLK); #1;
        d1_dma_req = 1; d1_dma_we = 0; d1_dma_addr = 32'h80;
        ack_c = -1; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (d1_mem_we != 2'd0) bad++;
            if (i == 1) begin
                chk("l1_busy_addr", d1_mem_addr, 32'h80);
                chk("l1_busy_wdata", d1_mem_wdata, 0);
                chk("l1_busy_ldtype", 32'(d1_mem_ldtype), 0);
            end
            if (d1_dma_ack) begin
                ack_c = i;
                chk("l1_dma_rdata", d1_dma_rdata, mem_val(32'h80));
                break;
            end
        end
        @(posedge CLK); #1;
        d1_dma_req = 0;
        chk("l1_ack_cycle", ack_c, 2);
        chk("l1_we_pulses", bad, 0);
        chk("l1_cpu_idle", 32'(d1_cpu_stall), 0);
        chk("l1_cpu_rdata", d1_cpu_rdata, 0);

        repeat (2) @(posedge CLK);
        chk("left_cpu", exp_cpu_q.size(), 0);
        chk("left_dma", exp_dma_q.size(), 0);
        chk("left_wr", exp_wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
